// File: rtl/phase_diff_smoother_if.sv
// Signal bundle between the zero-crossing phase stage and the phase smoother.
// The master side drives phase samples; the slave side returns the smoothed phase and status.
interface phase_diff_smoother_if;
  logic signed [15:0] phase_in;
  logic               phase_in_valid;
  logic        [7:0]  confidence_in;
  logic signed [15:0] phase_avg;
  logic               phase_out_valid;
  logic               sample_rejected;
  logic               locked;
  logic               stale;

  modport master (
    output phase_in, phase_in_valid, confidence_in,
    input  phase_avg, phase_out_valid, sample_rejected, locked, stale
  );

  modport slave (
    input  phase_in, phase_in_valid, confidence_in,
    output phase_avg, phase_out_valid, sample_rejected, locked, stale
  );
endinterface

// File: rtl/phase_diff_smoother.sv
// Wrap-aware exponential smoother for 0.1-degree phase samples (-1800..+1800) with
// confidence/outlier rejection, lock tracking and a stale-data timeout.
module phase_diff_smoother #(
  parameter int AVG_LOG2       = 3,
  parameter int MIN_CONF       = 100,
  parameter int OUTLIER_TH     = 300,
  parameter int OUTLIER_MAX    = 3,
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 3_500_000
) (
  input  logic clk,
  input  logic rst,
  phase_diff_smoother_if.slave bus
);

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int LC_W = $clog2(LOCK_COUNT + 2);
  localparam int OC_W = $clog2(OUTLIER_MAX + 2);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic signed [15:0] PH_MAX   = 16'sd1800;
  localparam logic signed [15:0] PH_MIN   = -16'sd1800;
  localparam logic signed [16:0] HALF     = 17'sd1800;
  localparam logic signed [16:0] FULL     = 17'sd3600;
  localparam logic signed [16:0] OUT_TH   = 17'(OUTLIER_TH);
  localparam logic        [7:0]  CONF_MIN = 8'(MIN_CONF);
  localparam logic [LC_W-1:0]    LOCK_TGT = LC_W'(LOCK_COUNT);
  localparam logic [OC_W-1:0]    OUT_TGT  = OC_W'(OUTLIER_MAX);
  localparam logic [TO_W-1:0]    TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  // ---------------- stage 1: rising-edge capture ----------------
  logic               valid_d_reg;
  logic               s1_valid_reg;
  logic signed [15:0] s1_phase_reg;
  logic               s1_ok_reg;
  logic               capture;
  logic               in_range;
  logic               conf_ok;

  assign capture  = bus.phase_in_valid & ~valid_d_reg;
  assign in_range = (bus.phase_in >= PH_MIN) && (bus.phase_in <= PH_MAX);
  assign conf_ok  = (bus.confidence_in >= CONF_MIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d_reg  <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_phase_reg <= '0;
      s1_ok_reg    <= 1'b0;
    end else begin
      valid_d_reg  <= bus.phase_in_valid;
      s1_valid_reg <= capture;
      if (capture) begin
        s1_phase_reg <= bus.phase_in;
        s1_ok_reg    <= in_range && conf_ok;
      end
    end
  end

  // ---------------- stage 2: wrapped difference ----------------
  logic signed [15:0] phase_avg_reg;
  logic signed [16:0] raw_delta;
  logic signed [16:0] wrap_delta;
  logic               s2_valid_reg;
  logic               s2_ok_reg;
  logic signed [15:0] s2_phase_reg;
  logic signed [16:0] s2_delta_reg;

  // phase_avg is already settled here: samples are at least two clocks apart.
  assign raw_delta = $signed({s1_phase_reg[15], s1_phase_reg})
                   - $signed({phase_avg_reg[15], phase_avg_reg});

  always_comb begin
    wrap_delta = raw_delta;
    if (raw_delta > HALF) begin
      wrap_delta = raw_delta - FULL;
    end else if (raw_delta < -HALF) begin
      wrap_delta = raw_delta + FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_ok_reg    <= 1'b0;
      s2_phase_reg <= '0;
      s2_delta_reg <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_ok_reg    <= s1_ok_reg;
        s2_phase_reg <= s1_phase_reg;
        s2_delta_reg <= wrap_delta;
      end
    end
  end

  // ---------------- stage 3: state, EMA and timeout ----------------
  logic [1:0]       state_reg, state_next;
  logic [LC_W-1:0]  lock_cnt_reg, lock_cnt_next;
  logic [OC_W-1:0]  outlier_cnt_reg, outlier_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic signed [15:0] phase_avg_next;
  logic             out_valid_reg, out_valid_next;
  logic             rejected_reg, rejected_next;
  logic             locked_reg, locked_next;
  logic             stale_reg, stale_next;

  logic signed [16:0] abs_delta;
  logic               is_outlier;
  logic signed [16:0] ema_step;
  logic signed [16:0] ema_sum;
  logic signed [15:0] ema_avg;
  logic [TO_W-1:0]    to_inc;
  logic               timed_out;
  logic [LC_W-1:0]    lock_inc;
  logic [OC_W-1:0]    outlier_inc;

  assign abs_delta   = (s2_delta_reg < 0) ? -s2_delta_reg : s2_delta_reg;
  assign is_outlier  = (abs_delta > OUT_TH);
  assign ema_step    = s2_delta_reg >>> AVG_LOG2;
  assign ema_sum     = $signed({phase_avg_reg[15], phase_avg_reg}) + ema_step;
  assign to_inc      = (to_cnt_reg == TO_MAX) ? TO_MAX : to_cnt_reg + 1'b1;
  assign timed_out   = (state_reg != EMPTY) && (to_inc == TO_MAX);
  assign lock_inc    = lock_cnt_reg + 1'b1;
  assign outlier_inc = outlier_cnt_reg + 1'b1;

  // Only values strictly outside +-1800 are folded, so both endpoints survive.
  always_comb begin
    ema_avg = 16'(ema_sum);
    if (ema_sum > HALF) begin
      ema_avg = 16'(ema_sum - FULL);
    end else if (ema_sum < -HALF) begin
      ema_avg = 16'(ema_sum + FULL);
    end
  end

  always_comb begin
    state_next       = state_reg;
    lock_cnt_next    = lock_cnt_reg;
    outlier_cnt_next = outlier_cnt_reg;
    to_cnt_next      = to_cnt_reg;
    phase_avg_next   = phase_avg_reg;
    out_valid_next   = 1'b0;
    rejected_next    = 1'b0;
    locked_next      = locked_reg;
    stale_next       = stale_reg;

    if (state_reg != EMPTY) begin
      to_cnt_next = to_inc;
    end
    if (timed_out) begin
      state_next       = EMPTY;
      stale_next       = 1'b1;
      locked_next      = 1'b0;
      lock_cnt_next    = '0;
      outlier_cnt_next = '0;
      to_cnt_next      = '0;
    end

    // Accepted samples override a coincident timeout.
    if (s2_valid_reg) begin
      if (!s2_ok_reg) begin
        rejected_next = 1'b1;
      end else begin
        case (state_reg)
          TRACK: begin
            out_valid_next   = 1'b1;
            outlier_cnt_next = '0;
            state_next       = TRACK;
            locked_next      = 1'b0;
            if (is_outlier) begin
              phase_avg_next = s2_phase_reg;
              lock_cnt_next  = LC_W'(1);
            end else begin
              phase_avg_next = ema_avg;
              lock_cnt_next  = lock_inc;
              if (lock_inc >= LOCK_TGT) begin
                state_next  = LOCKED;
                locked_next = 1'b1;
              end
            end
          end
          LOCKED: begin
            if (!is_outlier) begin
              out_valid_next   = 1'b1;
              phase_avg_next   = ema_avg;
              outlier_cnt_next = '0;
              state_next       = LOCKED;
              locked_next      = 1'b1;
            end else if (outlier_inc >= OUT_TGT) begin
              out_valid_next   = 1'b1;
              phase_avg_next   = s2_phase_reg;
              outlier_cnt_next = '0;
              lock_cnt_next    = LC_W'(1);
              state_next       = TRACK;
              locked_next      = 1'b0;
            end else begin
              rejected_next = 1'b1;
              if (!timed_out) begin
                outlier_cnt_next = outlier_inc;
              end
            end
          end
          default: begin
            out_valid_next   = 1'b1;
            phase_avg_next   = s2_phase_reg;
            lock_cnt_next    = LC_W'(1);
            outlier_cnt_next = '0;
            if (LOCK_COUNT <= 1) begin
              state_next  = LOCKED;
              locked_next = 1'b1;
            end else begin
              state_next  = TRACK;
              locked_next = 1'b0;
            end
          end
        endcase
        if (out_valid_next) begin
          stale_next  = 1'b0;
          to_cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= EMPTY;
      lock_cnt_reg    <= '0;
      outlier_cnt_reg <= '0;
      to_cnt_reg      <= '0;
      phase_avg_reg   <= '0;
      out_valid_reg   <= 1'b0;
      rejected_reg    <= 1'b0;
      locked_reg      <= 1'b0;
      stale_reg       <= 1'b1;
    end else begin
      state_reg       <= state_next;
      lock_cnt_reg    <= lock_cnt_next;
      outlier_cnt_reg <= outlier_cnt_next;
      to_cnt_reg      <= to_cnt_next;
      phase_avg_reg   <= phase_avg_next;
      out_valid_reg   <= out_valid_next;
      rejected_reg    <= rejected_next;
      locked_reg      <= locked_next;
      stale_reg       <= stale_next;
    end
  end

  assign bus.phase_avg       = phase_avg_reg;
  assign bus.phase_out_valid = out_valid_reg;
  assign bus.sample_rejected = rejected_reg;
  assign bus.locked          = locked_reg;
  assign bus.stale           = stale_reg;

endmodule

// File: tb/tb_phase_diff_smoother.sv
// Scoreboard bench for phase_diff_smoother: directed samples push hand-computed
// expectations; per-DUT monitors pop and compare on every output pulse.
module tb_phase_diff_smoother;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [15:0] stim_phase = '0;
  logic        [7:0]  stim_conf  = '0;
  logic               stim_valid = 1'b0;
  logic               sel_b      = 1'b0;

  phase_diff_smoother_if ifa ();
  phase_diff_smoother_if ifb ();

  assign ifa.phase_in       = stim_phase;
  assign ifa.confidence_in  = stim_conf;
  assign ifa.phase_in_valid = stim_valid & ~sel_b;
  assign ifb.phase_in       = stim_phase;
  assign ifb.confidence_in  = stim_conf;
  assign ifb.phase_in_valid = stim_valid & sel_b;

  phase_diff_smoother #(.TIMEOUT_CYCLES(1000)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  phase_diff_smoother #(.AVG_LOG2(0), .TIMEOUT_CYCLES(1000)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  typedef struct {
    bit                 kind;   // 1 = phase_out_valid, 0 = sample_rejected
    logic signed [15:0] avg;
    bit                 locked;
    bit                 stale;
    int                 cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_pulse(input string who, input exp_t e, input logic pv, input logic sr,
                             input logic signed [15:0] avg, input logic lk, input logic st);
    n_vec++;
    if (pv == sr || pv != e.kind || avg != e.avg || lk != e.locked || st != e.stale || cyc != e.cyc) begin
      n_miss++;
      $display("FAIL %s pulse: got valid=%0b rej=%0b avg=%0d locked=%0b stale=%0b cyc=%0d, want %s avg=%0d locked=%0b stale=%0b cyc=%0d",
               who, pv, sr, avg, lk, st, cyc, e.kind ? "valid" : "reject", e.avg, e.locked, e.stale, e.cyc);
    end else begin
      $display("ok   %s %s avg=%0d locked=%0b stale=%0b cyc=%0d",
               who, e.kind ? "valid " : "reject", avg, lk, st, cyc);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.phase_out_valid || ifa.sample_rejected) begin
      if (qa.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL dut_a unexpected pulse: valid=%0b rej=%0b avg=%0d cyc=%0d, want none",
                 ifa.phase_out_valid, ifa.sample_rejected, ifa.phase_avg, cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check_pulse("dut_a", e, ifa.phase_out_valid, ifa.sample_rejected,
                    ifa.phase_avg, ifa.locked, ifa.stale);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.phase_out_valid || ifb.sample_rejected) begin
      if (qb.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL dut_b unexpected pulse: valid=%0b rej=%0b avg=%0d cyc=%0d, want none",
                 ifb.phase_out_valid, ifb.sample_rejected, ifb.phase_avg, cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check_pulse("dut_b", e, ifb.phase_out_valid, ifb.sample_rejected,
                    ifb.phase_avg, ifb.locked, ifb.stale);
      end
    end
  end

  // One sample: valid held len cycles; phase is scrambled after the first
  // cycle so a late capture would show up as a wrong average.
  task automatic send(input bit b, input int ph, input int cf, input int len,
                      input bit kind, input int eavg, input bit elk, input bit est);
    exp_t e;
    @(negedge clk);
    sel_b      = b;
    stim_phase = 16'(ph);
    stim_conf  = 8'(cf);
    stim_valid = 1'b1;
    e.kind = kind; e.avg = 16'(eavg); e.locked = elk; e.stale = est; e.cyc = cyc + 3;
    if (b) qb.push_back(e); else qa.push_back(e);
    repeat (len) begin
      @(negedge clk);
      stim_phase = 16'(ph + 500);
    end
    stim_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("pending_expectations", qa.size() + qb.size(), 0);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("reset_avg_a",     int'(ifa.phase_avg), 0);
    check("reset_locked_a",  int'(ifa.locked), 0);
    check("reset_stale_a",   int'(ifa.stale), 1);
    check("reset_pulses_a",  int'(ifa.phase_out_valid) + int'(ifa.sample_rejected), 0);
    check("reset_stale_b",   int'(ifb.stale), 1);
    rst = 1'b0;

    // single 5-cycle pulse -> exactly one output
    send(0, 450, 255, 5, 1, 450, 0, 0);
    drain();

    // seed then EMA steps 10, 8, 7; lock on 4th output
    do_reset();
    send(0, 100, 255, 2, 1, 100, 0, 0);
    send(0, 180, 255, 2, 1, 110, 0, 0);
    send(0, 180, 255, 2, 1, 118, 0, 0);
    send(0, 180, 255, 2, 1, 125, 1, 0);
    drain();

    // outliers in LOCKED, invalid samples, boundaries
    do_reset();
    send(0, 100, 255, 2, 1, 100, 0, 0);
    send(0, 100, 255, 2, 1, 100, 0, 0);
    send(0, 100, 255, 2, 1, 100, 0, 0);
    send(0, 100, 255, 2, 1, 100, 1, 0);
    send(0, 600, 255, 2, 0, 100, 1, 0);
    send(0, 600, 255, 2, 0, 100, 1, 0);
    send(0, 600, 255, 2, 1, 600, 0, 0);
    send(0, 610,  50, 2, 0, 600, 0, 0);
    send(0, 2000, 255, 2, 0, 600, 0, 0);
    send(0, 1801, 255, 2, 0, 600, 0, 0);
    send(0, 620,  99, 2, 0, 600, 0, 0);
    send(0, 600, 100, 2, 1, 600, 0, 0);
    send(0, 600, 255, 2, 1, 600, 0, 0);
    send(0, 600, 255, 2, 1, 600, 1, 0);
    send(0, 1000, 255, 2, 0, 600, 1, 0);
    send(0, 1000,  50, 2, 0, 600, 1, 0);
    send(0, 1000, 255, 2, 0, 600, 1, 0);
    send(0, 650, 255, 2, 1, 606, 1, 0);
    send(0, 1000, 255, 2, 0, 606, 1, 0);
    send(0, 1000, 255, 2, 0, 606, 1, 0);
    send(0, -1800, 255, 2, 1, -1800, 0, 0);
    send(0, 1800, 255, 2, 1, -1800, 0, 0);
    drain();

    // wrap across +-1800
    do_reset();
    send(0, 1750, 255, 2, 1, 1750, 0, 0);
    send(0, -1750, 255, 2, 1, 1762, 0, 0);
    send(1, 1790, 255, 2, 1, 1790, 0, 0);
    send(1, -1780, 255, 2, 1, -1780, 0, 0);
    drain();

    // timeout to stale, reseed, then reset mid-pipeline
    do_reset();
    send(0, 200, 255, 2, 1, 200, 0, 0);
    send(0, 200, 255, 2, 1, 200, 0, 0);
    send(0, 200, 255, 2, 1, 200, 0, 0);
    send(0, 200, 255, 2, 1, 200, 1, 0);
    drain();
    repeat (970) @(negedge clk);
    check("before_timeout_stale",  int'(ifa.stale), 0);
    check("before_timeout_locked", int'(ifa.locked), 1);
    repeat (40) @(negedge clk);
    check("after_timeout_stale",   int'(ifa.stale), 1);
    check("after_timeout_locked",  int'(ifa.locked), 0);
    check("after_timeout_avg",     int'(ifa.phase_avg), 200);
    send(0, -300, 255, 2, 1, -300, 0, 0);
    drain();

    @(negedge clk);
    sel_b = 1'b0; stim_phase = 16'sd700; stim_conf = 8'd255; stim_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_avg",    int'(ifa.phase_avg), 0);
    check("midreset_stale",  int'(ifa.stale), 1);
    check("midreset_locked", int'(ifa.locked), 0);
    stim_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_reset_avg",   int'(ifa.phase_avg), 0);
    check("post_reset_stale", int'(ifa.stale), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
